// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor, LSB first, one bit per clock.
// A word is framed by an accepted start; bit 0 is taken in the accept cycle
// and the remaining WIDTH-1 bits follow back to back while busy is high.
// cout/ovf describe the most recently completed word and only change on its
// final bit.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic sub,
  input  logic x,
  input  logic y,
  output logic busy,
  output logic z,
  output logic z_valid,
  output logic z_last,
  output logic cout,
  output logic ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          c;
  logic          sub_r;

  logic          mode;
  logic          cin;
  logic          yb;
  logic          s;
  logic          cn;

  assign busy = (state == RUN);

  // Full-adder bit step; on accept the carry is reloaded from the new mode
  // so nothing leaks from the previous word.
  always_comb begin
    mode = sub;
    cin  = sub;
    if (state == RUN) begin
      mode = sub_r;
      cin  = c;
    end
    yb = y ^ mode;
    s  = x ^ yb ^ cin;
    cn = (x & yb) | (x & cin) | (yb & cin);
  end

  // Word framing, result bit register and end-of-word flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      c       <= 1'b0;
      sub_r   <= 1'b0;
      z       <= 1'b0;
      z_valid <= 1'b0;
      z_last  <= 1'b0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          z_last <= 1'b0;
          if (start) begin
            z       <= s;
            z_valid <= 1'b1;
            c       <= cn;
            sub_r   <= sub;
            cnt     <= CNT_ONE;
            state   <= RUN;
          end else begin
            z       <= 1'b0;
            z_valid <= 1'b0;
          end
        end
        RUN: begin
          z       <= s;
          z_valid <= 1'b1;
          c       <= cn;
          cnt     <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            z_last <= 1'b1;
            state  <= IDLE;
            cout   <= cn;
            // carry into the MSB differs from carry out of it
            ovf    <= c ^ cn;
          end else begin
            z_last <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial adder/subtractor for WIDTH-bit two's-complement words, LSB first, one bit per clock. Successor to the team's 1-bit serial adder: adds word framing with a start/busy handshake, add/subtract mode, per-word carry reset, and end-of-word carry-out and signed-overflow flags. Sits between serial shift-register operand sources and a serial result sink.

## Interface
- WIDTH, 8, word length in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a word; accepted only when busy=0; x/y carry bit 0 in the accept cycle.
- sub  in  1  mode, sampled with accepted start: 0 = x+y, 1 = x-y; held for the whole word.
- x  in  1  operand A serial bit, LSB first.
- y  in  1  operand B serial bit, LSB first.
- busy  out  1  word in progress; bits 1..WIDTH-1 are being consumed.
- z  out  1  registered result bit.
- z_valid  out  1  z holds a result bit this cycle.
- z_last  out  1  z is the MSB of the word; one-cycle pulse.
- cout  out  1  carry out of MSB for the last completed word; for subtract, 1 = no borrow (x>=y unsigned).
- ovf  out  1  signed overflow of the last completed word.

## Operation
- Internal state: busy, bit counter cnt (ceil(log2 WIDTH) bits), carry register c, latched mode sub_r.
- Bit step: yb = y XOR mode; s = x XOR yb XOR c_in; c_next = majority(x, yb, c_in).
- Accept (busy=0 and start=1): mode = sub, c_in = sub (two's-complement +1 for subtract), z <= s, z_valid <= 1, c <= c_next, sub_r <= sub, cnt <= 1, busy <= 1.
- Run (busy=1): mode = sub_r, c_in = c; z <= s, z_valid <= 1, c <= c_next, cnt <= cnt+1; start ignored.
- Final bit (busy=1, cnt = WIDTH-1): additionally z_last <= 1, busy <= 0, cout <= c_next, ovf <= c XOR c_next (carry into MSB XOR carry out of MSB).
- Idle with no start: z <= 0, z_valid <= 0, z_last <= 0; c, cnt hold; cout/ovf hold last values.
- cout/ovf change only on a final bit; stable until the next word completes.
- Carry never leaks between words: accept always reloads c_in from sub.
- Result is modulo 2^WIDTH; no saturation.

## Timing
- Reset (rst_n=0, asynchronous): busy=0, cnt=0, c=0, sub_r=0, z=0, z_valid=0, z_last=0, cout=0, ovf=0. Reset mid-word aborts it; no z_last or flag update for that word.
- Latency: input bit i sampled at edge i; z bit i valid after edge i (1 cycle). Word occupies WIDTH consecutive input cycles, no stalls.
- z_last and flag update appear after the edge sampling bit WIDTH-1; busy falls on that same edge.
- Back-to-back: start may be asserted in the cycle z_last=1 (busy=0 there); next word's bit 0 is taken with zero gap, z_valid stays high continuously.
- start while busy=1: no effect on mode, carry, counter or outputs.
- Source must present x/y bit k in the k-th cycle after accept; no backpressure.

## Test plan
- Add, WIDTH=8: start, sub=0, x=0x5A, y=0x33 -> z stream forms 0x8D over 8 cycles, z_last on 8th, cout=0, ovf=1.
- Subtract: sub=1, x=0x10, y=0x20 -> z=0xF0, cout=0 (borrow), ovf=0; then x=0x20, y=0x10 -> 0x10, cout=1, ovf=0.
- Wrap and carry isolation: x=0xFF+y=0x01 -> z=0x00, cout=1, ovf=0; immediately next word 0x00+0x00 (start on z_last cycle) -> z=0x00, cout=0, z_valid high for 16 straight cycles.
- Start ignored while busy: pulse start with sub=1 at bit 3 of an add 0x7F+0x01 -> result 0x80, ovf=1, cout=0; no restart, busy low exactly after 8 bits.
- Reset mid-word: assert rst_n=0 at bit 4 -> all outputs 0 immediately; after release, fresh word 0x03+0x04 -> 0x07, cout=0, ovf=0, flags unaffected by aborted word.
- Parameter sweep: WIDTH=2 and WIDTH=32 random add/sub vs. reference model, check z, cout, ovf every word.
